// File: rtl/lsu_pkg.sv
// ---------------------------------------------------------------------------
// lsu_pkg
// Shared definitions for the load/store unit:
//   - FSM state encodings (IDLE, REQ, WAIT, DONE)
//   - RV32I funct3 width/sign codes used by loads and stores
//   - access_ok(): legality + alignment check for a requested access
// ---------------------------------------------------------------------------
package lsu_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_REQ  = 2'd1;
    localparam state_t ST_WAIT = 2'd2;
    localparam state_t ST_DONE = 2'd3;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    // True when the funct3 code is legal for the access type and the low
    // address bits satisfy the natural alignment of the access width.
    function automatic logic access_ok(input logic       is_store,
                                       input logic [2:0] f3,
                                       input logic [1:0] a);
        logic legal;
        logic aligned;
        if (is_store) begin
            legal = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        end else begin
            legal = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                    (f3 == F3_BU) || (f3 == F3_HU);
        end
        case (f3)
            F3_H, F3_HU: aligned = ~a[0];
            F3_W:        aligned = (a == 2'b00);
            default:     aligned = 1'b1;
        endcase
        return legal && aligned;
    endfunction

endpackage

// File: rtl/lsu_if.sv
// ---------------------------------------------------------------------------
// lsu_if
// Request/grant/response memory bus between the LSU and memory.
//   mem_req    request, held until mem_gnt
//   mem_we     write enable
//   mem_addr   word-aligned address
//   mem_wstrb  byte strobes (stores only)
//   mem_wdata  store data on its byte lanes
//   mem_gnt    request accepted this cycle
//   mem_rvalid read data valid
//   mem_rdata  read word
// master = LSU side, slave = memory side.
// ---------------------------------------------------------------------------
interface lsu_if;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
        output mem_gnt, mem_rvalid, mem_rdata
    );

endinterface

// File: rtl/lsu_load_align.sv
// ---------------------------------------------------------------------------
// lsu_load_align
// Combinational load extractor: picks the byte/halfword addressed by
// addr_lo out of the read word and sign- or zero-extends it.
//   rdata   in  32  word returned by memory
//   addr_lo in  2   low address bits of the access
//   funct3  in  3   RV32I load width/sign code
//   data    out 32  extended load result
// ---------------------------------------------------------------------------
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [7:0]  lane [4];
    logic [7:0]  sel_b;
    logic [15:0] sel_h;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign lane[gi] = rdata[8*gi +: 8];
        end
    endgenerate

    assign sel_b = lane[addr_lo];
    assign sel_h = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        data = rdata;
        case (funct3)
            F3_B:    data = {{24{sel_b[7]}}, sel_b};
            F3_BU:   data = {24'b0, sel_b};
            F3_H:    data = {{16{sel_h[15]}}, sel_h};
            F3_HU:   data = {16'b0, sel_h};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// ---------------------------------------------------------------------------
// lsu
// RV32I load/store unit, one memory transaction at a time.
//   clk, reset          clock / synchronous active-high reset
//   start               one-cycle request (sampled only in IDLE)
//   is_store            1 = store, 0 = load
//   funct3              RV32I width/sign code
//   addr                effective address from the ALU
//   store_data          rs2 value, low-aligned
//   busy                high whenever the FSM is not IDLE
//   done                one-cycle completion pulse
//   fault               valid with done: illegal, misaligned or timeout
//   load_data           extended load result, held until the next done
//   bus                 memory bus (lsu_if.master)
// TIMEOUT bounds the cycles spent in REQ+WAIT before the access aborts.
// ---------------------------------------------------------------------------
module lsu
    import lsu_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        busy,
    output logic        done,
    output logic        fault,
    output logic [31:0] load_data,
    lsu_if.master       bus
);

    localparam int             CW      = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]  TO_LAST = CW'(TIMEOUT - 1);

    state_t      state_reg,     state_next;
    logic        is_store_reg,  is_store_next;
    logic [2:0]  funct3_reg,    funct3_next;
    logic [1:0]  addr_lo_reg,   addr_lo_next;
    logic        fault_reg,     fault_next;
    logic [31:0] load_data_reg, load_data_next;
    logic [31:0] mem_addr_reg,  mem_addr_next;
    logic [31:0] mem_wdata_reg, mem_wdata_next;
    logic [3:0]  mem_wstrb_reg, mem_wstrb_next;
    logic [CW-1:0] cnt_reg,     cnt_next;

    // Store lane steering, computed from the live core inputs so it can be
    // latched in the same cycle start is accepted.
    logic [3:0]  st_strb;
    logic [31:0] st_data;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_st_lane
            assign st_strb[gi] = (funct3 == F3_W) ? 1'b1 :
                                 (funct3 == F3_H) ? (addr[1] == (gi >= 2)) :
                                                    (addr[1:0] == 2'(gi));
            // Unselected lanes carry replicated data; the strobes mark
            // which lanes are meaningful.
            assign st_data[8*gi +: 8] = (funct3 == F3_W) ? store_data[8*gi +: 8] :
                                        (funct3 == F3_H) ? store_data[8*(gi%2) +: 8] :
                                                           store_data[7:0];
        end
    endgenerate

    logic [31:0] ld_ext;

    lsu_load_align u_load_align (
        .rdata   (bus.mem_rdata),
        .addr_lo (addr_lo_reg),
        .funct3  (funct3_reg),
        .data    (ld_ext)
    );

    always_comb begin
        state_next     = state_reg;
        is_store_next  = is_store_reg;
        funct3_next    = funct3_reg;
        addr_lo_next   = addr_lo_reg;
        fault_next     = fault_reg;
        load_data_next = load_data_reg;
        mem_addr_next  = mem_addr_reg;
        mem_wdata_next = mem_wdata_reg;
        mem_wstrb_next = mem_wstrb_reg;
        cnt_next       = cnt_reg;

        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    is_store_next  = is_store;
                    funct3_next    = funct3;
                    addr_lo_next   = addr[1:0];
                    mem_addr_next  = {addr[31:2], 2'b00};
                    mem_wdata_next = is_store ? st_data : '0;
                    mem_wstrb_next = is_store ? st_strb : '0;
                    cnt_next       = '0;
                    if (access_ok(is_store, funct3, addr[1:0])) begin
                        state_next = ST_REQ;
                        fault_next = 1'b0;
                    end else begin
                        // Rejected before touching the bus.
                        state_next     = ST_DONE;
                        fault_next     = 1'b1;
                        load_data_next = '0;
                    end
                end
            end
            ST_REQ: begin
                cnt_next = cnt_reg + 1'b1;
                if (bus.mem_gnt) begin
                    state_next = is_store_reg ? ST_DONE : ST_WAIT;
                end else if (cnt_reg == TO_LAST) begin
                    state_next     = ST_DONE;
                    fault_next     = 1'b1;
                    load_data_next = '0;
                end
            end
            ST_WAIT: begin
                cnt_next = cnt_reg + 1'b1;
                if (bus.mem_rvalid) begin
                    state_next     = ST_DONE;
                    load_data_next = ld_ext;
                end else if (cnt_reg == TO_LAST) begin
                    state_next     = ST_DONE;
                    fault_next     = 1'b1;
                    load_data_next = '0;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            is_store_reg  <= 1'b0;
            funct3_reg    <= 3'd0;
            addr_lo_reg   <= 2'd0;
            fault_reg     <= 1'b0;
            load_data_reg <= '0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            mem_wstrb_reg <= '0;
            cnt_reg       <= '0;
        end else begin
            state_reg     <= state_next;
            is_store_reg  <= is_store_next;
            funct3_reg    <= funct3_next;
            addr_lo_reg   <= addr_lo_next;
            fault_reg     <= fault_next;
            load_data_reg <= load_data_next;
            mem_addr_reg  <= mem_addr_next;
            mem_wdata_reg <= mem_wdata_next;
            mem_wstrb_reg <= mem_wstrb_next;
            cnt_reg       <= cnt_next;
        end
    end

    assign busy          = (state_reg != ST_IDLE);
    assign done          = (state_reg == ST_DONE);
    assign fault         = (state_reg == ST_DONE) && fault_reg;
    assign load_data     = load_data_reg;
    assign bus.mem_req   = (state_reg == ST_REQ);
    assign bus.mem_we    = (state_reg == ST_REQ) && is_store_reg;
    assign bus.mem_addr  = mem_addr_reg;
    assign bus.mem_wdata = mem_wdata_reg;
    assign bus.mem_wstrb = mem_wstrb_reg;

endmodule

// File: tb/tb_lsu.sv
// ---------------------------------------------------------------------------
// tb_lsu
// Directed bench for the load/store unit. Each access pushes its expected
// completion (latency, fault, load result, REQ cycle count) to a scoreboard
// when start is driven; the entry is popped and compared when done appears.
// Bus outputs are compared against the expected address/strobes/data in
// every REQ cycle. TIMEOUT is set to 8.
// ---------------------------------------------------------------------------
module tb_lsu;
    import lsu_pkg::*;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic        busy;
    logic        done;
    logic        fault;
    logic [31:0] load_data;

    lsu_if bus ();

    lsu #(.TIMEOUT(TO)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .is_store   (is_store),
        .funct3     (funct3),
        .addr       (addr),
        .store_data (store_data),
        .busy       (busy),
        .done       (done),
        .fault      (fault),
        .load_data  (load_data),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        fault;
        logic        chk_ld;
        logic [31:0] ld;
        int          lat;
        int          req_cycles;
    } exp_t;

    exp_t sb[$];
    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] lane_mask(input logic [3:0] s);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{s[i]}};
        return m;
    endfunction

    // One access: drive start in the current cycle (cycle 0), then act as
    // the memory (grant after gnt_dly extra REQ cycles, rvalid after rv_dly
    // extra WAIT cycles) until done appears or the cycle budget runs out.
    task automatic run(input string tag, input logic st, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] d,
                       input int gnt_dly, input int rv_dly, input logic [31:0] rd,
                       input logic junk,
                       input logic exp_fault, input logic chk_ld, input logic [31:0] exp_ld,
                       input int exp_lat, input int exp_req,
                       input logic [31:0] exp_addr, input logic [3:0] exp_strb,
                       input logic [31:0] exp_wdata);
        exp_t e;
        int   req_n;
        int   rv_n;
        bit   granted;
        bit   got;
        sb.push_back('{exp_fault, chk_ld, exp_ld, exp_lat, exp_req});
        start = 1'b1; is_store = st; funct3 = f3; addr = a; store_data = d;
        @(negedge clk);
        start = 1'b0;
        req_n = 0; rv_n = 0; granted = 1'b0; got = 1'b0;
        for (int c = 1; c <= 40 && !got; c++) begin
            bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; start = 1'b0;
            if (done) begin
                got = 1'b1;
                chk({tag, " sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk({tag, " latency"}, 32'(c), 32'(e.lat));
                    chk({tag, " fault"}, 32'(fault), 32'(e.fault));
                    chk({tag, " req_cycles"}, 32'(req_n), 32'(e.req_cycles));
                    if (e.chk_ld) chk({tag, " load_data"}, load_data, e.ld);
                end
            end else begin
                if (bus.mem_req) begin
                    chk({tag, " mem_addr"}, bus.mem_addr, exp_addr);
                    chk({tag, " mem_we"}, 32'(bus.mem_we), 32'(st));
                    chk({tag, " mem_wstrb"}, 32'(bus.mem_wstrb), 32'(exp_strb));
                    chk({tag, " mem_wdata"}, bus.mem_wdata & lane_mask(exp_strb), exp_wdata);
                    if (req_n == gnt_dly) begin
                        bus.mem_gnt = 1'b1;
                        granted = 1'b1;
                    end
                    req_n++;
                end else if (granted && !st) begin
                    if (rv_n == rv_dly) begin
                        bus.mem_rvalid = 1'b1;
                        bus.mem_rdata  = rd;
                    end
                    rv_n++;
                end
                // Competing requests while busy must be dropped.
                if (junk && busy) begin
                    start = 1'b1; is_store = 1'b1; funct3 = F3_W;
                    addr = 32'hDEAD_BEE0; store_data = 32'hFFFF_FFFF;
                end
            end
            @(negedge clk);
        end
        chk({tag, " done_seen"}, 32'(got), 32'd1);
        $display("txn %s: latency_exp=%0d fault=%0b load_data=%h", tag, exp_lat, fault, load_data);
        // First cycle after done: back in IDLE with the bus quiet.
        chk({tag, " idle_busy"}, 32'(busy), 32'd0);
        chk({tag, " idle_req"}, 32'(bus.mem_req), 32'd0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; is_store = 1'b0; funct3 = 3'd0;
        addr = '0; store_data = '0;
        bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
        @(negedge clk);
        @(negedge clk);
        chk("reset busy",      32'(busy), 32'd0);
        chk("reset done",      32'(done), 32'd0);
        chk("reset fault",     32'(fault), 32'd0);
        chk("reset load_data", load_data, 32'd0);
        chk("reset mem_req",   32'(bus.mem_req), 32'd0);
        chk("reset mem_we",    32'(bus.mem_we), 32'd0);
        chk("reset mem_addr",  bus.mem_addr, 32'd0);
        chk("reset mem_wdata", bus.mem_wdata, 32'd0);
        chk("reset mem_wstrb", 32'(bus.mem_wstrb), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        //   tag        st    f3     addr         data          gd rv rdata         junk flt  cld  exp_ld        lat req exp_addr      strb     wdata
        run("LBU 103",  1'b0, F3_BU, 32'h103,     32'h0,        0, 0, 32'h80AABBCC, 1'b0, 1'b0, 1'b1, 32'h00000080, 3, 1, 32'h100,     4'b0000, 32'h0);
        run("LW 20",    1'b0, F3_W,  32'h20,      32'h0,        2, 0, 32'h11223344, 1'b0, 1'b0, 1'b1, 32'h11223344, 5, 3, 32'h20,      4'b0000, 32'h0);
        run("SH 202",   1'b1, F3_H,  32'h202,     32'h1234ABCD, 0, 0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        2, 1, 32'h200,     4'b1100, 32'hABCD0000);
        run("SB 7",     1'b1, F3_B,  32'h7,       32'h0000005A, 0, 0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        2, 1, 32'h4,       4'b1000, 32'h5A000000);
        run("SW 10",    1'b1, F3_W,  32'h10,      32'hCAFEF00D, 1, 0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        3, 2, 32'h10,      4'b1111, 32'hCAFEF00D);
        run("LH slow",  1'b0, F3_H,  32'h1002,    32'h0,        4, 1, 32'h80017FFF, 1'b1, 1'b0, 1'b1, 32'hFFFF8001, 8, 5, 32'h1000,    4'b0000, 32'h0);
        run("LHU 102",  1'b0, F3_HU, 32'h102,     32'h0,        0, 0, 32'h80017FFF, 1'b0, 1'b0, 1'b1, 32'h00008001, 3, 1, 32'h100,     4'b0000, 32'h0);
        run("LW tmo",   1'b0, F3_W,  32'h40,      32'h0,        1000, 0, 32'h0,     1'b0, 1'b1, 1'b1, 32'h0,        9, 8, 32'h40,      4'b0000, 32'h0);
        run("LB 103",   1'b0, F3_B,  32'h103,     32'h0,        0, 0, 32'h80AABBCC, 1'b0, 1'b0, 1'b1, 32'hFFFFFF80, 3, 1, 32'h100,     4'b0000, 32'h0);
        run("LW mis",   1'b0, F3_W,  32'h101,     32'h0,        0, 0, 32'h0,        1'b0, 1'b1, 1'b1, 32'h0,        1, 0, 32'h100,     4'b0000, 32'h0);
        run("S f3=3",   1'b1, 3'd3,  32'h0,       32'h55,       0, 0, 32'h0,        1'b0, 1'b1, 1'b1, 32'h0,        1, 0, 32'h0,       4'b0000, 32'h0);
        run("L f3=6",   1'b0, 3'd6,  32'h0,       32'h0,        0, 0, 32'h0,        1'b0, 1'b1, 1'b1, 32'h0,        1, 0, 32'h0,       4'b0000, 32'h0);
        run("SH mis",   1'b1, F3_H,  32'h203,     32'h1234,     0, 0, 32'h0,        1'b0, 1'b1, 1'b1, 32'h0,        1, 0, 32'h200,     4'b0000, 32'h0);
        run("LB 103b",  1'b0, F3_B,  32'h103,     32'h0,        0, 0, 32'h80AABBCC, 1'b0, 1'b0, 1'b1, 32'hFFFFFF80, 3, 1, 32'h100,     4'b0000, 32'h0);

        // Reset while a load sits in WAIT; the late response must be ignored.
        start = 1'b1; is_store = 1'b0; funct3 = F3_W; addr = 32'h300;
        @(negedge clk);
        start = 1'b0;
        chk("rst req_before", 32'(bus.mem_req), 32'd1);
        bus.mem_gnt = 1'b1;
        @(negedge clk);
        bus.mem_gnt = 1'b0;
        chk("rst busy_in_wait", 32'(busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("rst busy",      32'(busy), 32'd0);
        chk("rst done",      32'(done), 32'd0);
        chk("rst fault",     32'(fault), 32'd0);
        chk("rst load_data", load_data, 32'd0);
        chk("rst mem_req",   32'(bus.mem_req), 32'd0);
        chk("rst mem_we",    32'(bus.mem_we), 32'd0);
        chk("rst mem_addr",  bus.mem_addr, 32'd0);
        chk("rst mem_wdata", bus.mem_wdata, 32'd0);
        chk("rst mem_wstrb", 32'(bus.mem_wstrb), 32'd0);
        $display("txn reset-in-WAIT: busy=%0b load_data=%h", busy, load_data);
        reset = 1'b0;
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h12345678;
        @(negedge clk);
        bus.mem_rvalid = 1'b0;
        chk("stale done",      32'(done), 32'd0);
        chk("stale busy",      32'(busy), 32'd0);
        @(negedge clk);
        chk("stale done2",     32'(done), 32'd0);
        chk("stale load_data", load_data, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
